// File: rtl/sauria_div_pkg.sv
// Shared types and configuration checks for the SAURIA sequential divider.
package sauria_div_pkg;

    // Controller states: accept, iterate, apply signs, present result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Legal iteration-per-clock settings for a given operand width
    function automatic bit steps_ok(input int data_w, input int steps);
        return ((steps == 1) || (steps == 2) || (steps == 4)) &&
               (data_w >= 4) && ((data_w % 2) == 0) && ((data_w % steps) == 0);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration on magnitudes.
module div_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    // Shifted partial remainder needs one extra bit before the trial subtract
    logic        [DATA_W:0]   rem_sh;
    logic signed [DATA_W+1:0] trial;

    assign rem_sh = {rem, quo[DATA_W-1]};
    assign trial  = $signed({1'b0, rem_sh}) - $signed({2'b00, divisor});

    // A negative trial restores the shifted remainder; rem_sh then fits DATA_W bits
    assign rem_next = (trial < 0) ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], ~(trial < 0)};

endmodule

// File: rtl/sauria_seq_divider.sv
// Iterative restoring integer divider with valid/ready on request and result.
// Signed mode divides magnitudes and fixes signs afterwards (C truncation).
module sauria_seq_divider
    import sauria_div_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int SIGNED        = 1,
    parameter int STEPS_PER_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_div_by_zero
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W / STEPS_PER_CYC - 1);

    if (!steps_ok(DATA_W, STEPS_PER_CYC)) begin : g_bad_cfg
        $error("sauria_seq_divider: illegal DATA_W / STEPS_PER_CYC combination");
    end

    // Two's-complement negate when requested; used for magnitudes and sign fix
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              sign_q;
    logic              sign_r;
    logic              sa;
    logic              sb;

    assign sa      = (SIGNED != 0) ? i_dividend[DATA_W-1] : 1'b0;
    assign sb      = (SIGNED != 0) ? i_divisor[DATA_W-1]  : 1'b0;
    assign o_ready = (state == IDLE);

    logic [DATA_W-1:0] rem_c [STEPS_PER_CYC+1];
    logic [DATA_W-1:0] quo_c [STEPS_PER_CYC+1];

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar s = 0; s < STEPS_PER_CYC; s++) begin : g_step
        div_step #(
            .DATA_W (DATA_W)
        ) u_step (
            .rem      (rem_c[s]),
            .quo      (quo_c[s]),
            .divisor  (dvs_q),
            .rem_next (rem_c[s+1]),
            .quo_next (quo_c[s+1])
        );
    end

    // Working datapath: latch magnitudes on accept, advance the step chain in CALC
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (i_valid) begin
                    dvs_q  <= cond_neg(i_divisor, sb);
                    sign_q <= sa ^ sb;
                    sign_r <= sa;
                    if (i_divisor == '0) begin
                        // Zero divisor: result is all-ones / untouched dividend
                        quo_q <= '1;
                        rem_q <= i_dividend;
                    end else begin
                        quo_q <= cond_neg(i_dividend, sa);
                        rem_q <= '0;
                    end
                end
            end
            CALC: begin
                rem_q <= rem_c[STEPS_PER_CYC];
                quo_q <= quo_c[STEPS_PER_CYC];
            end
            default: ;
        endcase
    end

    // Control FSM and registered result outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            o_valid       <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_divisor == '0) begin
                            state <= DONE;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    o_quotient    <= cond_neg(quo_q, sign_q);
                    o_remainder   <= cond_neg(rem_q, sign_r);
                    o_div_by_zero <= 1'b0;
                    o_valid       <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (!o_valid) begin
                        // Only the zero-divisor path arrives here unpublished
                        o_quotient    <= quo_q;
                        o_remainder   <= rem_q;
                        o_div_by_zero <= 1'b1;
                        o_valid       <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sauria_seq_divider.sv
// Directed bench for sauria_seq_divider: unsigned, signed and 4-step variants.
module tb_sauria_seq_divider;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_ready [3];
    logic         out_valid [3];
    logic         out_dbz   [3];
    logic [W-1:0] dvd       [3];
    logic [W-1:0] dvs       [3];
    logic [W-1:0] quo       [3];
    logic [W-1:0] rem       [3];

    int checks = 0;
    int errors = 0;

    sauria_seq_divider #(.DATA_W(W), .SIGNED(0), .STEPS_PER_CYC(1)) u_uns (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
        .i_dividend(dvd[0]), .i_divisor(dvs[0]), .o_valid(out_valid[0]),
        .i_ready(in_ready[0]), .o_quotient(quo[0]), .o_remainder(rem[0]),
        .o_div_by_zero(out_dbz[0]));

    sauria_seq_divider #(.DATA_W(W), .SIGNED(1), .STEPS_PER_CYC(1)) u_sgn (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
        .i_dividend(dvd[1]), .i_divisor(dvs[1]), .o_valid(out_valid[1]),
        .i_ready(in_ready[1]), .o_quotient(quo[1]), .o_remainder(rem[1]),
        .o_div_by_zero(out_dbz[1]));

    sauria_seq_divider #(.DATA_W(W), .SIGNED(0), .STEPS_PER_CYC(4)) u_s4 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid[2]), .o_ready(out_ready[2]),
        .i_dividend(dvd[2]), .i_divisor(dvs[2]), .o_valid(out_valid[2]),
        .i_ready(in_ready[2]), .o_quotient(quo[2]), .o_remainder(rem[2]),
        .o_div_by_zero(out_dbz[2]));

    typedef struct {
        int           u;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int u);
        int n = 0;
        while (out_ready[u] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_send", {31'b0, out_ready[u]}, 32'd1);
    endtask

    // Present a request at the falling edge; it is taken at the next rising edge
    task automatic send(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid[u] = 1'b1;
        dvd[u]      = a;
        dvs[u]      = b;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic wait_valid(input int u, output int lat);
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vt[0]  = '{0, 16'd1000,  16'd7,      16'd142,    16'd6,      1'b0, 17};
        vt[1]  = '{0, 16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1, 1};
        vt[2]  = '{0, 16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 17};
        vt[3]  = '{0, 16'd5,     16'd9,      16'd0,      16'd5,      1'b0, 17};
        vt[4]  = '{0, 16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 17};
        vt[5]  = '{0, 16'h8000,  16'hFFFF,   16'd0,      16'h8000,   1'b0, 17};
        vt[6]  = '{1, 16'hFFF9,  16'd2,      16'hFFFD,   16'hFFFF,   1'b0, 17};
        vt[7]  = '{1, 16'h8000,  16'hFFFF,   16'h8000,   16'd0,      1'b0, 17};
        vt[8]  = '{1, 16'd7,     16'hFFFE,   16'hFFFD,   16'd1,      1'b0, 17};
        vt[9]  = '{1, 16'hFFF9,  16'hFFFE,   16'd3,      16'hFFFF,   1'b0, 17};
        vt[10] = '{1, 16'd1234,  16'd0,      16'hFFFF,   16'h04D2,   1'b1, 1};
        vt[11] = '{1, 16'hFF9C,  16'd0,      16'hFFFF,   16'hFF9C,   1'b1, 1};
        vt[12] = '{1, 16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 17};
        vt[13] = '{1, 16'hFFFF,  16'd16,     16'd0,      16'hFFFF,   1'b0, 17};
        vt[14] = '{2, 16'd255,   16'd16,     16'd15,     16'd15,     1'b0, 5};
        vt[15] = '{2, 16'd60000, 16'd300,    16'd200,    16'd0,      1'b0, 5};
        vt[16] = '{2, 16'hFFFF,  16'h00FF,   16'h0101,   16'd0,      1'b0, 5};
        vt[17] = '{2, 16'd50,    16'd0,      16'hFFFF,   16'd50,     1'b1, 1};

        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0;
            in_ready[u] = 1'b1;
            dvd[u]      = '0;
            dvs[u]      = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check("reset_valid", {31'b0, out_valid[u]}, 32'd0);
            check("reset_ready", {31'b0, out_ready[u]}, 32'd1);
            check("reset_quo",   {16'b0, quo[u]},       32'd0);
            check("reset_rem",   {16'b0, rem[u]},       32'd0);
            check("reset_dbz",   {31'b0, out_dbz[u]},   32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors, each followed by an immediate result handshake
        for (int i = 0; i < NV; i++) begin
            wait_ready(vt[i].u);
            send(vt[i].u, vt[i].a, vt[i].b);
            wait_valid(vt[i].u, lat);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_quo", i), {16'b0, quo[vt[i].u]}, {16'b0, vt[i].q});
            check($sformatf("v%0d_rem", i), {16'b0, rem[vt[i].u]}, {16'b0, vt[i].r});
            check($sformatf("v%0d_dbz", i), {31'b0, out_dbz[vt[i].u]}, {31'b0, vt[i].z});
            check($sformatf("v%0d_busy", i), {31'b0, out_ready[vt[i].u]}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_drop", i), {31'b0, out_valid[vt[i].u]}, 32'd0);
            check($sformatf("v%0d_ready_back", i), {31'b0, out_ready[vt[i].u]}, 32'd1);
        end

        // Backpressure: result held for 5 cycles while a new request is offered
        in_ready[1] = 1'b0;
        send(1, 16'd100, 16'd7);
        wait_valid(1, lat);
        check("bp_latency", lat, 17);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid[1] = 1'b1;
            dvd[1]      = 16'd1;
            dvs[1]      = 16'd1;
            @(posedge clk); #1;
            check("bp_valid_held", {31'b0, out_valid[1]}, 32'd1);
            check("bp_quo_held",   {16'b0, quo[1]},       32'd14);
            check("bp_rem_held",   {16'b0, rem[1]},       32'd2);
            check("bp_ready_low",  {31'b0, out_ready[1]}, 32'd0);
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        in_ready[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'b0, out_valid[1]}, 32'd0);
        check("bp_release_ready", {31'b0, out_ready[1]}, 32'd1);
        @(posedge clk); #1;
        check("bp_no_stray_accept", {31'b0, out_ready[1]}, 32'd1);

        // Reset during the 5th CALC cycle discards the operation
        send(0, 16'd1000, 16'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'b0, out_valid[0]}, 32'd0);
        check("rst_mid_ready", {31'b0, out_ready[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1) seen++;
        end
        check("rst_no_partial_result", seen, 0);
        check("rst_quo_cleared", {16'b0, quo[0]}, 32'd0);

        wait_ready(2);
        send(2, 16'd255, 16'd16);
        wait_valid(2, lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_quo", {16'b0, quo[2]}, 32'd15);
        check("post_rst_rem", {16'b0, rem[2]}, 32'd15);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sauria_seq_divider.md
# sauria_seq_divider

Iterative radix-2 restoring integer divider, the inverse counterpart of the SAURIA combinational multiplier tree. Computes quotient and remainder of a DATA_W-bit dividend by a DATA_W-bit divisor over several cycles, with valid/ready handshakes on both sides. Used by the SAURIA core for post-accumulation rescaling and normalisation, where area matters more than throughput.

## Interface
- DATA_W, 16, operand and result width; even, ≥4.
- SIGNED, 1, 1 = two's-complement operands and results, 0 = unsigned.
- STEPS_PER_CYC, 1, restoring iterations per clock; one of 1, 2, 4; must divide DATA_W.
- Reset: one clock; reset is asynchronous and active-high.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  divider can accept a request.
- i_dividend  in  DATA_W  dividend.
- i_divisor  in  DATA_W  divisor.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_quotient  out  DATA_W  quotient.
- o_remainder  out  DATA_W  remainder.
- o_div_by_zero  out  1  result came from a zero divisor.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. o_ready = (state == IDLE).
- IDLE: on i_valid && o_ready, latch operands. Divisor == 0 → DONE directly. Otherwise → CALC, iteration counter loaded with DATA_W/STEPS_PER_CYC − 1.
- Signed mode: magnitudes are latched along with sign_q = sa ^ sb and sign_r = sa. Unsigned mode: operands are used as-is and signs are 0.
- CALC: each step shifts {rem, quo} left by 1. trial = rem − |divisor|. If trial ≥ 0, rem = trial and quo LSB = 1. Otherwise rem is restored. STEPS_PER_CYC steps are chained combinationally per clock. When the counter reaches 0 → FIX.
- FIX: negate quo if sign_q and negate rem if sign_r (truncating division, C semantics) → DONE.
- DONE: o_valid = 1. Outputs hold stable until i_ready. On i_valid... the transition is o_valid && i_ready → IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified), o_div_by_zero = 1.
- Signed overflow (min_int / −1): quotient = min_int, remainder = 0, o_div_by_zero = 0. This falls out naturally from magnitude arithmetic and requires no special path.
- i_valid while o_ready = 0 is ignored; the requester must hold it.
- Reset (at any time, including mid-CALC): state IDLE, o_valid 0, o_ready 1, o_quotient/o_remainder 0, o_div_by_zero 0, counter 0. Any in-flight operation is discarded with no partial result emitted.

## Timing
- Accept at edge k. Normal path: o_valid rises at edge k + DATA_W/STEPS_PER_CYC + 1 (defaults: 17 cycles).
- Divide-by-zero path: o_valid at edge k + 1.
- Result handshake at edge m → o_ready = 1 from edge m. The earliest next accept is at edge m + 1.
- Back-to-back throughput is one result per DATA_W/STEPS_PER_CYC + 3 cycles.
- All outputs are registered. o_ready is decoded from the state register with no combinational path from inputs.

## Structure
- Package sauria_div_pkg holds the state enum type (IDLE/CALC/FIX/DONE) and the legal STEPS_PER_CYC check function.
- Sub-module div_step is one combinational restoring iteration: inputs rem, quo, divisor; outputs next rem and next quo. It is instantiated STEPS_PER_CYC times in a generate chain.

## Test plan
- Unsigned path: SIGNED=0, dividend 1000, divisor 7 → quotient 142, remainder 6, o_valid exactly 17 cycles after accept.
- Signed negative dividend: SIGNED=1, dividend −7 (0xFFF9), divisor 2 → quotient 0xFFFD (−3), remainder 0xFFFF (−1).
- Divide by zero: dividend 1234, divisor 0 → quotient 0xFFFF, remainder 1234, o_div_by_zero 1, o_valid 1 cycle after accept.
- Signed overflow: dividend 0x8000, divisor 0xFFFF → quotient 0x8000, remainder 0, o_div_by_zero 0.
- Backpressure: hold i_ready = 0 for 5 cycles in DONE → outputs stable, o_ready stays 0, a new i_valid is not accepted; the result completes on release.
- Reset mid-operation: assert i_rst in the 5th CALC cycle → o_valid stays 0 and o_ready = 1 immediately. A following request (STEPS_PER_CYC=4 variant, 255/16) → quotient 15, remainder 15 after 5 cycles.
